// File: rtl/instr_sequencer_if.sv
// Fetch/dispatch bus between the instruction sequencer, program memory,
// the instruction decoder and the execution units.
interface instr_sequencer_if #(
   parameter int unsigned PC_W    = 6,
   parameter int unsigned INSTR_W = 16
);
   localparam int unsigned START_W = 6;

   // program memory port
   logic [PC_W-1:0]    pm_addr;
   logic               pm_rd;
   logic [INSTR_W-1:0] pm_data;

   // decoder port
   logic [INSTR_W-1:0] instr;
   logic               ir_load;
   logic [START_W-1:0] dec_start;

   // execution unit completion / branch request
   logic               exec_done;
   logic               br_taken;
   logic [PC_W-1:0]    br_target;

   // sequencer side
   modport master (
      output pm_addr, pm_rd, instr, ir_load,
      input  pm_data, dec_start, exec_done, br_taken, br_target
   );

   // memory / decoder / execution side
   modport slave (
      input  pm_addr, pm_rd, instr, ir_load,
      output pm_data, dec_start, exec_done, br_taken, br_target
   );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/dispatch controller: reads a word from program memory, hands it to
// the decoder with a one-cycle IRin strobe, waits for the started execution
// unit and then advances the PC sequentially or to a branch target.
module instr_sequencer #(
   parameter int unsigned PC_W    = 6,
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   instr_sequencer_if.master bus,
   output logic              busy,
   output logic              err
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MEMWAIT,
      S_LOAD,
      S_SETTLE,
      S_EXEC,
      S_NEXT,
      S_ERROR
   } state_t;

   state_t             state;
   logic [PC_W-1:0]    pc;
   logic               pm_rd_q;
   logic [INSTR_W-1:0] instr_q;
   logic               ir_load_q;
   logic [CNT_W-1:0]   wait_cnt;
   logic               br_taken_q;
   logic [PC_W-1:0]    br_target_q;

   // The program memory address is the PC register itself.
   assign bus.pm_addr = pc;
   assign bus.pm_rd   = pm_rd_q;
   assign bus.instr   = instr_q;
   assign bus.ir_load = ir_load_q;

   // Sequencer FSM; every output is set on the edge that enters its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         pm_rd_q     <= 1'b0;
         instr_q     <= '0;
         ir_load_q   <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
         wait_cnt    <= '0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  state   <= S_FETCH;
                  pm_rd_q <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            S_FETCH: begin
               state   <= S_MEMWAIT;
               pm_rd_q <= 1'b0;
            end

            // read data is valid one cycle after the read strobe
            S_MEMWAIT: begin
               state     <= S_LOAD;
               instr_q   <= bus.pm_data;
               ir_load_q <= 1'b1;
            end

            S_LOAD: begin
               state     <= S_SETTLE;
               ir_load_q <= 1'b0;
            end

            // decoder latches on the falling IRin edge; give it a cycle
            S_SETTLE: begin
               state    <= S_EXEC;
               wait_cnt <= '0;
            end

            // completion beats timeout when both land on the last cycle
            S_EXEC: begin
               if (bus.dec_start == '0) begin
                  state      <= S_NEXT;
                  br_taken_q <= 1'b0;
               end else if (bus.exec_done) begin
                  state       <= S_NEXT;
                  br_taken_q  <= bus.br_taken;
                  br_target_q <= bus.br_target;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  state <= S_ERROR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            // PC wraps naturally at 2^PC_W
            S_NEXT: begin
               pc <= br_taken_q ? br_target_q : pc + PC_W'(1);
               if (run) begin
                  state   <= S_FETCH;
                  pm_rd_q <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            // sticky until reset
            S_ERROR: begin
               pm_rd_q   <= 1'b0;
               ir_load_q <= 1'b0;
               busy      <= 1'b0;
               err       <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural memory and execution unit, with a
// PC/timing reference model kept as plain arithmetic per instruction.
module tb_instr_sequencer;
   localparam int unsigned PC_W    = 6;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst;
   logic run;
   logic busy;
   logic err;

   instr_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .bus  (bus),
      .busy (busy),
      .err  (err)
   );

   always #5 clk = ~clk;

   logic [INSTR_W-1:0] pm [64];
   logic [PC_W-1:0]    model_pc;
   int                 checks = 0;
   int                 errors = 0;

   // synchronous program memory: data one cycle after the read strobe
   always @(posedge clk) begin
      if (bus.pm_rd === 1'b1) bus.pm_data <= pm[bus.pm_addr];
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // junk on the execution-unit lines where the sequencer must ignore them
   task automatic drive_noise();
      bus.exec_done = 1'($urandom_range(0, 1));
      bus.br_taken  = 1'($urandom_range(0, 1));
      bus.br_target = 6'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      bus.dec_start = '0;
      bus.exec_done = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_target = '0;
      tick();
      tick();
      rst = 1'b0;
      model_pc = '0;
   endtask

   // One full instruction, starting at the negedge just before FETCH and
   // ending at the negedge inside NEXT. lat = EXEC cycle on which done comes.
   task automatic do_instr(input logic [5:0] ds, input int lat, input logic bt,
                           input logic [5:0] tgt, input bit drop_run);
      int n;
      logic [INSTR_W-1:0] word;
      word = pm[model_pc];
      n = (ds == 6'd0) ? 1 : lat;
      tick(); // FETCH
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b1010 || bus.pm_addr !== model_pc) begin
         errors++;
         $display("FAIL fetch: rd/ld/busy/err=%b addr=%0d, want 1010 addr=%0d",
                  {bus.pm_rd, bus.ir_load, busy, err}, bus.pm_addr, model_pc);
      end
      bus.dec_start = ds;
      drive_noise();
      tick(); // MEMWAIT
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy} !== 3'b001) begin
         errors++;
         $display("FAIL memwait: rd/ld/busy=%b want 001", {bus.pm_rd, bus.ir_load, busy});
      end
      drive_noise();
      tick(); // LOAD
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy} !== 3'b011 || bus.instr !== word) begin
         errors++;
         $display("FAIL load: rd/ld/busy=%b instr=%h, want 011 instr=%h",
                  {bus.pm_rd, bus.ir_load, busy}, bus.instr, word);
      end
      drive_noise();
      tick(); // SETTLE
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy} !== 3'b001 || bus.instr !== word) begin
         errors++;
         $display("FAIL settle: rd/ld/busy=%b instr=%h, want 001 instr=%h",
                  {bus.pm_rd, bus.ir_load, busy}, bus.instr, word);
      end
      drive_noise();
      for (int c = 1; c <= n; c++) begin
         tick(); // EXEC cycle c
         checks++;
         if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b0010 || bus.instr !== word) begin
            errors++;
            $display("FAIL exec%0d: rd/ld/busy/err=%b instr=%h, want 0010 instr=%h",
                     c, {bus.pm_rd, bus.ir_load, busy, err}, bus.instr, word);
         end
         if (drop_run && c == 1) run = 1'b0;
         if (ds == 6'd0) begin
            drive_noise();
         end else if (c == n) begin
            bus.exec_done = 1'b1;
            bus.br_taken  = bt;
            bus.br_target = tgt;
         end else begin
            bus.exec_done = 1'b0;
            bus.br_taken  = 1'b1;
            bus.br_target = 6'($urandom);
         end
      end
      tick(); // NEXT
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b0010) begin
         errors++;
         $display("FAIL next: rd/ld/busy/err=%b want 0010", {bus.pm_rd, bus.ir_load, busy, err});
      end
      drive_noise();
      model_pc = (ds != 6'd0 && bt) ? tgt : 6'((int'(model_pc) + 1) % 64);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b0000 || bus.pm_addr !== 6'd0 ||
             bus.instr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_idle: rd/ld/busy/err=%b addr=%0d instr=%h, want 0000 0 0000",
                     {bus.pm_rd, bus.ir_load, busy, err}, bus.pm_addr, bus.instr);
         end
         tick();
      end
   endtask

   task automatic test_first_instr();
      pm[0] = 16'h1041;
      do_reset();
      run = 1'b1;
      do_instr(6'b000001, 3, 1'b0, 6'd0, 1'b0);
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_nop_wrap();
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 66; i++) do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_branch();
      do_reset();
      run = 1'b1;
      do_instr(6'b000010, 2, 1'b1, 6'd20, 1'b0);
      do_instr(6'b000100, 4, 1'b0, 6'($urandom), 1'b0);
      do_instr(6'b100000, 1, 1'b1, 6'd63, 1'b0);
      do_instr(6'b000001, 2, 1'b0, 6'd5, 1'b0);
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_timeout();
      do_reset();
      run = 1'b1;
      tick(); // FETCH
      bus.dec_start = 6'b000001;
      tick(); // MEMWAIT
      tick(); // LOAD
      tick(); // SETTLE
      bus.exec_done = 1'b0;
      for (int c = 1; c <= int'(TIMEOUT); c++) begin
         tick();
         checks++;
         if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_wait%0d: busy/err=%b want 10", c, {busy, err});
         end
         bus.br_taken = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b0001) begin
            errors++;
            $display("FAIL tmo_error%0d: rd/ld/busy/err=%b want 0001", i,
                     {bus.pm_rd, bus.ir_load, busy, err});
         end
         drive_noise();
      end
      do_reset();
      checks++;
      if ({busy, err} !== 2'b00) begin
         errors++;
         $display("FAIL tmo_clear: busy/err=%b want 00", {busy, err});
      end
      run = 1'b1;
      do_instr(6'b000001, int'(TIMEOUT), 1'b0, 6'd0, 1'b0);
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_run_stop();
      do_reset();
      run = 1'b1;
      do_instr(6'b000001, 3, 1'b1, 6'd40, 1'b0);
      do_instr(6'b000010, 2, 1'b0, 6'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({bus.pm_rd, busy} !== 2'b00 || bus.pm_addr !== model_pc) begin
            errors++;
            $display("FAIL stop_idle: rd/busy=%b addr=%0d, want 00 addr=%0d",
                     {bus.pm_rd, busy}, bus.pm_addr, model_pc);
         end
      end
      run = 1'b1;
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_reset_in_load();
      do_reset();
      run = 1'b1;
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
      tick(); // FETCH
      bus.dec_start = 6'b000001;
      tick(); // MEMWAIT
      tick(); // LOAD
      checks++;
      if (bus.ir_load !== 1'b1 || bus.instr !== pm[model_pc]) begin
         errors++;
         $display("FAIL rst_pre: ir_load=%b instr=%h, want 1 instr=%h",
                  bus.ir_load, bus.instr, pm[model_pc]);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.pm_rd, bus.ir_load, busy, err} !== 4'b0000 || bus.pm_addr !== 6'd0 ||
          bus.instr !== 16'h0000) begin
         errors++;
         $display("FAIL rst_in_load: rd/ld/busy/err=%b addr=%0d instr=%h, want 0000 0 0000",
                  {bus.pm_rd, bus.ir_load, busy, err}, bus.pm_addr, bus.instr);
      end
      rst = 1'b0;
      run = 1'b1;
      model_pc = '0;
      do_instr(6'd0, 1, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ds;
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ds = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         do_instr(ds, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 6'($urandom), 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      run = 1'b0;
      for (int i = 0; i < 64; i++) pm[i] = 16'($urandom) | 16'h0001;
      test_reset();
      test_first_instr();
      test_nop_wrap();
      test_branch();
      test_timeout();
      test_run_stop();
      test_reset_in_load();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
